// File: rtl/clk_reset_sequencer.sv
// Staged reset release for the pixel clock domain: waits for a stable wizard lock,
// then deasserts per-subsystem resets in order, re-asserting all at once on lock loss or soft request.
//
// state     | meaning
// WAIT_LOCK | all stages held in reset, waiting for synchronized lock
// STABILIZE | lock seen, counting STABLE_CYCLES before releasing stage 0
// RELEASE   | releasing stages 1..NUM_STAGES-1, one every STAGE_GAP cycles
// RUN       | all stages released
module clk_reset_sequencer #(
  parameter int NUM_STAGES    = 3,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  locked,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic [1:0]            state_o,
  output logic [7:0]            lock_loss_cnt
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int IW = $clog2(NUM_STAGES + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  locked_meta_q, locked_s_q;
  logic [NUM_STAGES-1:0] stage_rst_n_q, stage_rst_n_d;
  logic                  seq_done_q, seq_done_d;
  logic [SW-1:0]         stab_cnt_q, stab_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            lock_loss_cnt_q, lock_loss_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_meta_q   <= 1'b0;
      locked_s_q      <= 1'b0;
      state_q         <= WAIT_LOCK;
      stage_rst_n_q   <= '0;
      seq_done_q      <= 1'b0;
      stab_cnt_q      <= '0;
      gap_cnt_q       <= '0;
      idx_q           <= '0;
      lock_loss_cnt_q <= '0;
    end else begin
      locked_meta_q   <= locked;
      locked_s_q      <= locked_meta_q;
      state_q         <= state_d;
      stage_rst_n_q   <= stage_rst_n_d;
      seq_done_q      <= seq_done_d;
      stab_cnt_q      <= stab_cnt_d;
      gap_cnt_q       <= gap_cnt_d;
      idx_q           <= idx_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    stage_rst_n_d   = stage_rst_n_q;
    seq_done_d      = seq_done_q;
    stab_cnt_d      = stab_cnt_q;
    gap_cnt_d       = gap_cnt_q;
    idx_d           = idx_q;
    lock_loss_cnt_d = lock_loss_cnt_q;

    if (state_q == WAIT_LOCK) begin
      stage_rst_n_d = '0;
      seq_done_d    = 1'b0;
      if (locked_s_q) begin
        state_d    = STABILIZE;
        stab_cnt_d = '0;
      end
    end else if (!locked_s_q || soft_rst_req) begin
      // lock loss wins over a coincident soft request so it is always counted
      state_d       = WAIT_LOCK;
      stage_rst_n_d = '0;
      seq_done_d    = 1'b0;
      stab_cnt_d    = '0;
      gap_cnt_d     = '0;
      idx_d         = '0;
      if (!locked_s_q && lock_loss_cnt_q != 8'hFF) begin
        lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
      end
    end else begin
      case (state_q)
        STABILIZE: begin
          stab_cnt_d = stab_cnt_q + 1'b1;
          if (stab_cnt_q == STABLE_LAST) begin
            stab_cnt_d       = '0;
            stage_rst_n_d[0] = 1'b1;
            if (NUM_STAGES == 1) begin
              state_d    = RUN;
              seq_done_d = 1'b1;
            end else begin
              state_d   = RELEASE;
              idx_d     = IW'(1);
              gap_cnt_d = '0;
            end
          end
        end
        RELEASE: begin
          gap_cnt_d = gap_cnt_q + 1'b1;
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (idx_q == IW'(i)) stage_rst_n_d[i] = 1'b1;
            end
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d    = RUN;
              seq_done_d = 1'b1;
              idx_d      = '0;
            end
          end
        end
        default: begin
          stage_rst_n_d = '1;
          seq_done_d    = 1'b1;
        end
      endcase
    end
  end

  assign stage_rst_n   = stage_rst_n_q;
  assign seq_done      = seq_done_q;
  assign state_o       = state_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Scoreboard bench for clk_reset_sequencer: two instances (3 stages and 1 stage) share stimulus;
// an arithmetic model of the release timeline predicts every cycle's outputs.
module tb_clk_reset_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic locked = 1'b0;
  logic soft_rst_req = 1'b0;

  logic [2:0] st_a;
  logic       done_a;
  logic [1:0] state_a;
  logic [7:0] loss_a;
  logic [0:0] st_b;
  logic       done_b;
  logic [1:0] state_b;
  logic [7:0] loss_b;

  always #5 clk = ~clk;

  clk_reset_sequencer #(.NUM_STAGES(3), .STABLE_CYCLES(8), .STAGE_GAP(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .locked(locked), .soft_rst_req(soft_rst_req),
    .stage_rst_n(st_a), .seq_done(done_a), .state_o(state_a), .lock_loss_cnt(loss_a));

  clk_reset_sequencer #(.NUM_STAGES(1), .STABLE_CYCLES(5), .STAGE_GAP(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .locked(locked), .soft_rst_req(soft_rst_req),
    .stage_rst_n(st_b), .seq_done(done_b), .state_o(state_b), .lock_loss_cnt(loss_b));

  typedef struct {
    logic [2:0] st_a;
    logic       done_a;
    logic [1:0] state_a;
    logic [0:0] st_b;
    logic       done_b;
    logic [1:0] state_b;
    logic [7:0] loss;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // model: lock sync pipe, whether a sequence is in progress, edges since it started
  bit m_s1, m_s2, m_active;
  int m_t, m_loss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int released(input int t, input int n, input int s, input int g);
    int r;
    if (t < s) return 0;
    r = 1 + (t - s) / g;
    return (r > n) ? n : r;
  endfunction

  function automatic logic [1:0] exp_state(input int r, input int n);
    if (!m_active) return 2'd0;
    if (r == 0) return 2'd1;
    if (r == n) return 2'd3;
    return 2'd2;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_active = 0; m_t = 0; m_loss = 0;
  endtask

  task automatic step(input logic lk, input logic sr);
    exp_t e;
    int ra, rb;
    @(negedge clk);
    locked = lk;
    soft_rst_req = sr;
    if (m_active && (!m_s2 || sr)) begin
      m_active = 0;
      if (!m_s2 && m_loss < 255) m_loss++;
    end else if (m_active) begin
      m_t++;
    end else if (m_s2) begin
      m_active = 1;
      m_t = 0;
    end
    m_s2 = m_s1;
    m_s1 = lk;
    ra = m_active ? released(m_t, 3, 8, 4) : 0;
    rb = m_active ? released(m_t, 1, 5, 3) : 0;
    e.st_a    = 3'((1 << ra) - 1);
    e.done_a  = (ra == 3);
    e.state_a = exp_state(ra, 3);
    e.st_b    = 1'(rb);
    e.done_b  = (rb == 1);
    e.state_b = exp_state(rb, 1);
    e.loss    = 8'(m_loss);
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_stage_a", 32'(st_a), 32'(e.st_a));
        chk("sb_done_a", 32'(done_a), 32'(e.done_a));
        chk("sb_state_a", 32'(state_a), 32'(e.state_a));
        chk("sb_loss_a", 32'(loss_a), 32'(e.loss));
        chk("sb_stage_b", 32'(st_b), 32'(e.st_b));
        chk("sb_done_b", 32'(done_b), 32'(e.done_b));
        chk("sb_state_b", 32'(state_b), 32'(e.state_b));
        chk("sb_loss_b", 32'(loss_b), 32'(e.loss));
      end
    end
  end

  task automatic post_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int hi, lo;
    model_reset();
    #1;
    chk("reset_stage_a", 32'(st_a), 0);
    chk("reset_state_a", 32'(state_a), 0);
    chk("reset_loss_a", 32'(loss_a), 0);
    chk("reset_done_b", 32'(done_b), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);

    // cold start; posedge following iteration i is T0+i
    for (int i = 0; i < 22; i++) begin
      step(1'b1, 1'b0);
      post_edge();
      chk($sformatf("cold_state_a_%0d", i), 32'(state_a), (i < 2) ? 0 : (i < 10) ? 1 : (i < 18) ? 2 : 3);
      chk($sformatf("cold_stage_a_%0d", i), 32'(st_a), (i < 10) ? 0 : (i < 14) ? 1 : (i < 18) ? 3 : 7);
      chk($sformatf("cold_done_a_%0d", i), 32'(done_a), (i >= 18) ? 1 : 0);
      chk($sformatf("cold_state_b_%0d", i), 32'(state_b), (i < 2) ? 0 : (i < 7) ? 1 : 3);
      chk($sformatf("cold_stage_b_%0d", i), 32'(st_b), (i >= 7) ? 1 : 0);
    end

    // lock loss in RUN: locked low before T1, resets at T1+2
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b0);
      post_edge();
      chk($sformatf("loss_run_stage_%0d", j), 32'(st_a), (j < 2) ? 7 : 0);
      chk($sformatf("loss_run_done_%0d", j), 32'(done_a), (j < 2) ? 1 : 0);
      chk($sformatf("loss_run_cnt_%0d", j), 32'(loss_a), (j < 2) ? 0 : 1);
    end

    // one-cycle lock glitch at T0+5 during STABILIZE
    for (int i = 0; i < 31; i++) begin
      step((i == 5) ? 1'b0 : 1'b1, 1'b0);
      post_edge();
      if (i == 7) begin
        chk("glitch_state", 32'(state_a), 0);
        chk("glitch_cnt", 32'(loss_a), 2);
      end
      if (i == 8) chk("glitch_restart", 32'(state_a), 1);
      if (i == 15) chk("glitch_full_wait", 32'(st_a), 0);
      if (i == 16) chk("glitch_release0", 32'(st_a), 1);
      if (i == 24) chk("glitch_run", 32'(state_a), 3);
    end

    // soft reset at T0+12 while releasing
    repeat (3) step(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, (i == 12) ? 1'b1 : 1'b0);
      post_edge();
      if (i == 11) chk("soft_pre_state", 32'(state_a), 2);
      if (i == 12) begin
        chk("soft_stage", 32'(st_a), 0);
        chk("soft_state", 32'(state_a), 0);
        chk("soft_cnt_unchanged", 32'(loss_a), 3);
      end
      if (i == 13) chk("soft_restab", 32'(state_a), 1);
      if (i == 28) chk("soft_not_done", 32'(done_a), 0);
      if (i == 29) chk("soft_done", 32'(st_a), 7);
    end

    // lock loss coinciding with a soft request at the FSM
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    post_edge();
    chk("simul_state", 32'(state_a), 0);
    chk("simul_cnt", 32'(loss_a), 4);
    step(1'b0, 1'b0);

    // asynchronous reset between edges while releasing
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    locked = 1'b0;
    soft_rst_req = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("async_stage_a", 32'(st_a), 0);
    chk("async_state_a", 32'(state_a), 0);
    chk("async_loss_a", 32'(loss_a), 0);
    chk("async_done_a", 32'(done_a), 0);
    chk("async_state_b", 32'(state_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // saturation of the loss counter
    for (int i = 0; i < 320; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    repeat (3) step(1'b0, 1'b0);
    post_edge();
    chk("sat_cnt", 32'(loss_a), 255);

    // random lock segments with sporadic soft requests
    for (int s = 0; s < 150; s++) begin
      hi = $urandom_range(1, 40);
      lo = $urandom_range(1, 4);
      for (int i = 0; i < hi; i++) step(1'b1, ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
      for (int i = 0; i < lo; i++) step(1'b0, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end
    repeat (3) step(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_reset_sequencer.md
# clk_reset_sequencer

Power-up and recovery reset sequencer for the pixel clock domain generated by `clk_wiz_0`. It watches the clock wizard's `locked` indication and, once the clock has been stable for a programmable interval, releases per-subsystem active-low resets in a fixed order: VGA timing first, then the renderer, then game logic. On lock loss or a software request, it immediately re-asserts all stage resets and reruns the sequence. It runs in the pixel clock domain.

## Interface
- `NUM_STAGES`, default 3: number of staged reset outputs. Legal range 1..8.
- `STABLE_CYCLES`, default 1024: number of consecutive synchronized-lock cycles required before the first release. Must be ≥1.
- `STAGE_GAP`, default 16: number of cycles between successive stage releases. Must be ≥1.

Ports:
- `clk` in 1: pixel clock (`clk_out1` of the wizard). Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: wizard lock flag. Asynchronous to `clk`; synchronized internally.
- `soft_rst_req` in 1: single-cycle pulse requesting a rerun of the sequence.
- `stage_rst_n` out `NUM_STAGES`: active-low reset per subsystem. Bit 0 is released first.
- `seq_done` out 1: high while all stages are released.
- `state_o` out 2: FSM state. WAIT_LOCK=0, STABILIZE=1, RELEASE=2, RUN=3.
- `lock_loss_cnt` out 8: saturating count of lock losses.

## Operation
- `locked` passes through a 2-flop synchronizer to produce `locked_s`. The FSM uses only `locked_s`.
- All outputs are registered.
- **WAIT_LOCK:** all `stage_rst_n`=0 and `seq_done`=0. When `locked_s`=1, go to STABILIZE and clear the stable counter.
- **STABILIZE:** the stable counter increments each cycle while `locked_s`=1. When it reaches `STABLE_CYCLES`, release stage 0 on that same edge.
  - If `NUM_STAGES`=1, go directly to RUN with `seq_done`=1.
  - Otherwise go to RELEASE with stage index 1 and gap counter 0.
- **RELEASE:** the gap counter increments each cycle. When it reaches `STAGE_GAP`:
  - release stage index k, increment k, and clear the gap counter;
  - when the last stage is released, go to RUN and set `seq_done`=1 on the same edge.
- **RUN:** hold all `stage_rst_n`=1 and `seq_done`=1.
- **Lock loss** (`locked_s`=0 in STABILIZE, RELEASE or RUN):
  - on that edge, all `stage_rst_n`=0, `seq_done`=0, state goes to WAIT_LOCK;
  - `lock_loss_cnt` +1, saturating at 255.
- **Soft reset:** `soft_rst_req`=1 in STABILIZE, RELEASE or RUN has the same effect as lock loss, but the counter is not incremented. It is ignored in WAIT_LOCK.
- **Simultaneous lock loss and soft request:** treated as lock loss (counter increments).
- Released stages never re-assert individually. Re-assertion is always all-stages-at-once.
- Counter widths are `$clog2(max+1)` of their terminal values. No wrap-around is reachable, because counters clear on every state change.

## Timing
- **Reset** (`rst_n`=0, asynchronous):
  - `stage_rst_n`=0, `seq_done`=0, `state_o`=0, `lock_loss_cnt`=0;
  - synchronizer flops=0, counters=0.
- **Reset deassertion:** the FSM starts in WAIT_LOCK. Removal is assumed synchronous to `clk` by the board-level reset bridge.
- **Lock latency:** let T0 be the first edge that samples `locked`=1. Then `locked_s`=1 after T0+1, and the FSM enters STABILIZE at edge T0+2.
- **Release times:** stage k releases at edge T0+2+`STABLE_CYCLES`+k·`STAGE_GAP`. `seq_done` rises together with stage `NUM_STAGES`-1.
- **Lock-loss latency:** if `locked` falls before edge T1, all resets assert at edge T1+2.
- **Soft-request latency:** `soft_rst_req` sampled high at edge T2 asserts all resets at T2.
- **Reset mid-operation:** `rst_n`=0 in any state forces the reset values immediately, with no clock required.

## Test plan
Unless noted, parameters are `NUM_STAGES`=3, `STABLE_CYCLES`=8, `STAGE_GAP`=4.

- **Cold start:** after `rst_n` release, raise `locked` before edge T0.
  - Required: `stage_rst_n` goes 000→001 at T0+10, →011 at T0+14, →111 at T0+18.
  - `seq_done`=1 at T0+18; `state_o` steps 0→1 (T0+2) →2 (T0+10) →3 (T0+18).
- **Lock glitch in STABILIZE:** drop `locked` for 1 cycle at T0+5.
  - Required: state returns to 0 and `lock_loss_cnt`=1; the sequence restarts from the new lock edge with the full 8-cycle wait.
- **Lock loss in RUN:** drop `locked` before edge T1.
  - Required: `stage_rst_n`=000 and `seq_done`=0 at T1+2; `lock_loss_cnt` increments.
- **Soft reset in RELEASE:** pulse `soft_rst_req` at T0+12.
  - Required: `stage_rst_n`=000 at T0+12; `lock_loss_cnt` unchanged; the resequence completes 18 cycles after the next lock detection.
- **Edge cases:**
  - Simultaneous soft request and lock loss: counter increments.
  - 300 lock losses: `lock_loss_cnt` saturates at 255.
  - `NUM_STAGES`=1: `stage_rst_n`=1 and `seq_done`=1 on the same edge, with state 1→3.
- **Asynchronous reset mid-RELEASE:** assert `rst_n`=0 between edges.
  - Required: all outputs return to reset values before the next edge.
